mem_access_unit: RTL

Load/store front end that sits directly upstream of the byte-addressed 4 KiB dual-port data RAM. It drives the RAM's read address, write address, write data and write enable, and consumes its 32-bit little-endian read word. It accepts one core request at a time with a req/ack handshake and supports byte, halfword and word loads with sign or zero extension. The RAM always writes 4 bytes, so byte and halfword stores use an internal read-modify-write sequence.

---
 rtl/mem_access_unit_pkg.sv | 16 +
 rtl/mem_access_unit_if.sv | 29 ++
 rtl/mem_access_unit_ld_extend.sv | 22 ++
 rtl/mem_access_unit.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the load/store front end: access sizes and FSM states.
package mem_access_unit_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_MERGE = 3'd2,
    ST_WR    = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/mem_access_unit_if.sv
// Core request/response handshake plus the RAM read/write ports, bundled together.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              store;
  logic [1:0]        size;
  logic              uns;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              ack;
  logic              busy;
  logic [ADDR_W-1:0] ram_addr_r;
  logic [ADDR_W-1:0] ram_addr_w;
  logic [31:0]       ram_wdata;
  logic              ram_we;
  logic [31:0]       ram_rdata;

  modport slave (
    input  req, store, size, uns, addr, wdata, ram_rdata,
    output rdata, ack, busy, ram_addr_r, ram_addr_w, ram_wdata, ram_we
  );

  modport master (
    output req, store, size, uns, addr, wdata, ram_rdata,
    input  rdata, ack, busy, ram_addr_r, ram_addr_w, ram_wdata, ram_we
  );
endinterface

// File: rtl/mem_access_unit_ld_extend.sv
// Sign/zero extension of the low byte or halfword of a 32-bit word; size 11 acts as word.
module mem_access_unit_ld_extend
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  output logic [31:0] ext_o
);

  // Select the extension for the requested access size.
  always_comb begin
    ext_o = word_i;
    case (size_i)
      SIZE_B:  ext_o = {{24{~uns_i & word_i[7]}}, word_i[7:0]};
      SIZE_H:  ext_o = {{16{~uns_i & word_i[15]}}, word_i[15:0]};
      SIZE_W:  ext_o = word_i;
      default: ext_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end for a 32-bit-write RAM; sub-word stores go through read-modify-write.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int RAM_BITS = 12
) (
  input  logic             m_clock,
  input  logic             p_reset,
  mem_access_unit_if.slave bus
);

  if (RAM_BITS < 1 || RAM_BITS > ADDR_W) begin : g_ram_bits_check
    $error("mem_access_unit: RAM_BITS must lie in 1..ADDR_W");
  end

  state_e            state_q, state_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] ram_addr_r_q, ram_addr_r_d;
  logic [ADDR_W-1:0] ram_addr_w_q, ram_addr_w_d;
  logic [31:0]       ram_wdata_q, ram_wdata_d;
  logic              ram_we_q, ram_we_d;
  logic [31:0]       ext_s;
  logic [31:0]       merge_s;

  mem_access_unit_ld_extend u_ld_extend (
    .word_i (bus.ram_rdata),
    .size_i (size_q),
    .uns_i  (uns_q),
    .ext_o  (ext_s)
  );

  // Byte-lane merge: new low lanes from the store data, upper lanes kept from the RAM word.
  always_comb begin
    merge_s = wdata_q;
    case (size_q)
      SIZE_B:  merge_s = {bus.ram_rdata[31:8], wdata_q[7:0]};
      SIZE_H:  merge_s = {bus.ram_rdata[31:16], wdata_q[15:0]};
      default: merge_s = wdata_q;
    endcase
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead so they leave registered.
  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    uns_d        = uns_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    ack_d        = 1'b0;
    busy_d       = 1'b0;
    ram_addr_r_d = ram_addr_r_q;
    ram_addr_w_d = ram_addr_w_q;
    ram_wdata_d  = ram_wdata_q;
    ram_we_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          size_d  = bus.size;
          uns_d   = bus.uns;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          if (!bus.store) begin
            state_d      = ST_RD;
            ram_addr_r_d = bus.addr;
          end else if (bus.size == SIZE_B || bus.size == SIZE_H) begin
            state_d      = ST_MERGE;
            ram_addr_r_d = bus.addr;
          end else begin
            state_d      = ST_WR;
            ram_addr_w_d = bus.addr;
            ram_wdata_d  = bus.wdata;
            ram_we_d     = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD: begin
        rdata_d = ext_s;
        ack_d   = 1'b1;
        state_d = ST_DONE;
      end
      ST_MERGE: begin
        ram_addr_w_d = addr_q;
        ram_wdata_d  = merge_s;
        ram_we_d     = 1'b1;
        state_d      = ST_WR;
      end
      ST_WR: begin
        ack_d   = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset; reset discards any latched request.
  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      state_q      <= ST_IDLE;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 32'h0000_0000;
      rdata_q      <= 32'h0000_0000;
      ack_q        <= 1'b0;
      busy_q       <= 1'b0;
      ram_addr_r_q <= '0;
      ram_addr_w_q <= '0;
      ram_wdata_q  <= 32'h0000_0000;
      ram_we_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      ack_q        <= ack_d;
      busy_q       <= busy_d;
      ram_addr_r_q <= ram_addr_r_d;
      ram_addr_w_q <= ram_addr_w_d;
      ram_wdata_q  <= ram_wdata_d;
      ram_we_q     <= ram_we_d;
    end
  end

  assign bus.rdata      = rdata_q;
  assign bus.ack        = ack_q;
  assign bus.busy       = busy_q;
  assign bus.ram_addr_r = ram_addr_r_q;
  assign bus.ram_addr_w = ram_addr_w_q;
  assign bus.ram_wdata  = ram_wdata_q;
  // Gate the enable with reset so a reset arriving during WR cannot commit a partial store.
  assign bus.ram_we     = ram_we_q & ~p_reset;

endmodule
